// File: rtl/adc_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : adc_seq_pkg                                                   |
// | Description: Shared widths, FSM encoding and helpers for the LTC2308 scan  |
// |              sequencer.                                                    |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package adc_seq_pkg;

  localparam int ADC_RES = 12;   // sample width from the driver
  localparam int CH_W    = 3;    // channel index width
  localparam int CODE_W  = 4;    // driver channel code {diff, ch}

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  // Lowest set bit of an (up to) 8-bit mask; 0 when the mask is empty.
  function automatic logic [CH_W-1:0] lowest_set(input logic [7:0] m);
    logic [CH_W-1:0] low;
    low = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) low = CH_W'(i);
    end
    return low;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_seq_next_ch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : adc_seq_next_ch                                               |
// | Description: Combinational picker: next set mask bit strictly above cur,   |
// |              wrapping to the lowest set bit, plus the highest set bit.     |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module adc_seq_next_ch
  import adc_seq_pkg::*;
#(
  parameter int NUM_CH = 8
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur,
  output logic [CH_W-1:0]   nxt,
  output logic              wrapped,
  output logic [CH_W-1:0]   highest
);

  logic [CH_W-1:0] w_low;

  // Scan downward so the last hit is the lowest qualifying bit.
  always_comb begin
    w_low   = '0;
    nxt     = '0;
    wrapped = 1'b1;
    highest = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) w_low = CH_W'(i);
      if (mask[i] && (i > int'(cur))) begin
        nxt     = CH_W'(i);
        wrapped = 1'b0;
      end
    end
    if (wrapped) nxt = w_low;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask[i]) highest = CH_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_channel_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : adc_channel_sequencer                                         |
// | Description: Scan controller for the adc_ltc2308 driver. Rotates through   |
// |              an enabled-channel mask one channel per frame and tags each   |
// |              sample with the channel it was converted on (one-frame        |
// |              config-to-data pipeline). Optional macro ADC_SEQ_HOLD_EN adds |
// |              a per-channel latest-sample bank with rd_ch/rd_data ports.    |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module adc_channel_sequencer
  import adc_seq_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int DIFF_MODE = 0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               run,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic               sleep_req,
  output logic               adc_start,
  output logic               adc_sleep,
  output logic [CODE_W-1:0]  adc_channel,
  input  logic               adc_ready,
  input  logic [ADC_RES-1:0] adc_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [ADC_RES-1:0] m_data,
  output logic [CH_W-1:0]    m_ch,
  output logic               m_last,
  output logic               overrun,
  input  logic               overrun_clr,
  output logic               busy
`ifdef ADC_SEQ_HOLD_EN
  ,
  input  logic [CH_W-1:0]    rd_ch,
  output logic [ADC_RES-1:0] rd_data
`endif
);

  localparam logic c_diff = (DIFF_MODE != 0);

  logic [1:0]         r_state;
  logic               r_start;
  logic [CH_W-1:0]    r_cur_ch;
  logic [CH_W-1:0]    r_pend_ch;
  logic               r_pend_valid;
  logic [NUM_CH-1:0]  r_mask_q;
  logic               r_sleep_q;

  logic               r_m_valid;
  logic [ADC_RES-1:0] r_m_data;
  logic [CH_W-1:0]    r_m_ch;
  logic               r_m_last;
  logic               r_overrun;

  logic [CH_W-1:0]    w_nxt;
  logic               w_wrapped;
  logic [CH_W-1:0]    w_highest;
  logic [CH_W-1:0]    w_new_low;
  logic               w_mask_nz;
  logic               w_tagged;
  logic               w_load;
  logic               w_drop;

  adc_seq_next_ch #(
    .NUM_CH (NUM_CH)
  ) u_next (
    .mask    (r_mask_q),
    .cur     (r_cur_ch),
    .nxt     (w_nxt),
    .wrapped (w_wrapped),
    .highest (w_highest)
  );

  // A new scan pass starts from the lowest bit of the freshly sampled mask.
  assign w_new_low = lowest_set(8'(ch_mask));
  assign w_mask_nz = |ch_mask;

  // A sample carries a known tag only once a channel is pending in RUN.
  assign w_tagged = (r_state == ST_RUN) && run && adc_ready && r_pend_valid;
  assign w_load   = w_tagged && (!r_m_valid || m_ready);
  assign w_drop   = w_tagged && !w_load;

  // Scan FSM: channel rotation, pipeline tag and mask/sleep re-latch at wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_start      <= 1'b0;
      r_cur_ch     <= '0;
      r_pend_ch    <= '0;
      r_pend_valid <= 1'b0;
      r_mask_q     <= '0;
      r_sleep_q    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (run && w_mask_nz) begin
            r_mask_q     <= ch_mask;
            r_sleep_q    <= sleep_req;
            r_cur_ch     <= w_new_low;
            r_pend_valid <= 1'b0;
            r_start      <= 1'b1;
            r_state      <= ST_PRIME;
          end
        end
        ST_PRIME, ST_RUN: begin
          if (!run) begin
            r_state      <= ST_IDLE;
            r_start      <= 1'b0;
            r_pend_valid <= 1'b0;
          end else if (adc_ready) begin
            // The channel configured this frame is converted into next frame's data.
            r_pend_ch    <= r_cur_ch;
            r_pend_valid <= 1'b1;
            r_state      <= ST_RUN;
            if (!w_wrapped) begin
              r_cur_ch <= w_nxt;
            end else begin
              r_mask_q  <= ch_mask;
              r_sleep_q <= sleep_req;
              if (w_mask_nz) begin
                r_cur_ch <= w_new_low;
              end else begin
                r_state      <= ST_IDLE;
                r_start      <= 1'b0;
                r_pend_valid <= 1'b0;
              end
            end
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_start      <= 1'b0;
          r_pend_valid <= 1'b0;
        end
      endcase
    end
  end

  // One-deep output register; a tagged sample that cannot be loaded is lost.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_ch    <= '0;
      r_m_last  <= 1'b0;
    end else if (w_load) begin
      r_m_valid <= 1'b1;
      r_m_data  <= adc_data;
      r_m_ch    <= r_pend_ch;
      r_m_last  <= (r_pend_ch == w_highest);
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  // Sticky overrun flag; a new drop beats a simultaneous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

`ifdef ADC_SEQ_HOLD_EN
  logic [ADC_RES-1:0] r_bank [NUM_CH];

  // Latest tagged sample per channel, captured even when the stream drops it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) r_bank[i] <= '0;
    end else if (w_tagged) begin
      r_bank[r_pend_ch] <= adc_data;
    end
  end

  assign rd_data = (int'(rd_ch) < NUM_CH) ? r_bank[rd_ch] : '0;
`endif

  assign adc_start   = r_start;
  assign adc_sleep   = r_sleep_q;
  assign adc_channel = {c_diff, r_cur_ch};
  assign busy        = (r_state != ST_IDLE);
  assign m_valid     = r_m_valid;
  assign m_data      = r_m_data;
  assign m_ch        = r_m_ch;
  assign m_last      = r_m_last;
  assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_adc_channel_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_adc_channel_sequencer                                      |
// | Description: Self-checking bench for adc_channel_sequencer with a frame-   |
// |              level LTC2308 driver model and a behavioural scan model.      |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_adc_channel_sequencer;

  localparam int FRAME = 80;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic [7:0]  ch_mask = 8'h00;
  logic        sleep_req = 1'b0;
  logic        adc_ready = 1'b0;
  logic [11:0] adc_data = 12'h000;
  logic        m_ready = 1'b0;
  logic        overrun_clr = 1'b0;

  logic        adc_start, adc_sleep, m_valid, m_last, overrun, busy;
  logic [3:0]  adc_channel;
  logic [11:0] m_data;
  logic [2:0]  m_ch;
`ifdef ADC_SEQ_HOLD_EN
  logic [2:0]  rd_ch = 3'd0;
  logic [11:0] rd_data;
`endif

  adc_channel_sequencer #(.NUM_CH(8), .DIFF_MODE(0)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .run         (run),
    .ch_mask     (ch_mask),
    .sleep_req   (sleep_req),
    .adc_start   (adc_start),
    .adc_sleep   (adc_sleep),
    .adc_channel (adc_channel),
    .adc_ready   (adc_ready),
    .adc_data    (adc_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_ch        (m_ch),
    .m_last      (m_last),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .busy        (busy)
`ifdef ADC_SEQ_HOLD_EN
    ,
    .rd_ch       (rd_ch),
    .rd_data     (rd_data)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- LTC2308 driver model ----------------
  // Config is captured mid-frame; data returned is the conversion configured
  // in the previous frame. The first frame after start returns junk.
  int         fcnt = 0;
  bit         first = 1'b1;
  logic [2:0] cfg = 3'd0;
  logic [2:0] prev_cfg = 3'd0;

  initial begin
    forever begin
      @(posedge clock);
      #1;
      adc_ready = 1'b0;
      if (!reset_n || !adc_start) begin
        fcnt  = 0;
        first = 1'b1;
      end else begin
        fcnt++;
        if (fcnt == 20) cfg = adc_channel[2:0];
        if (fcnt == FRAME) begin
          adc_ready = 1'b1;
          adc_data  = first ? 12'hFFF : {prev_cfg, 9'h0A5};
          prev_cfg  = cfg;
          first     = 1'b0;
          fcnt      = 0;
        end
      end
    end
  end

  // ---------------- behavioural scan model ----------------
  function automatic int low_of(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int high_of(input logic [7:0] m);
    for (int i = 7; i >= 0; i--) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int above(input logic [7:0] m, input int c);
    for (int i = c + 1; i < 8; i++) if (m[i]) return i;
    return -1;
  endfunction

  bit          e_scan, e_have, e_sleep, e_valid, e_last, e_ovr;
  logic [7:0]  e_mask;
  int          e_cur, e_pend, e_ch;
  logic [11:0] e_data;

  task automatic model_reset();
    e_scan = 0; e_have = 0; e_sleep = 0; e_valid = 0; e_last = 0; e_ovr = 0;
    e_mask = 8'h00; e_cur = 0; e_pend = 0; e_ch = 0; e_data = 12'h000;
  endtask

  task automatic model_step();
    bit t, tl, drop;
    int tch, n;
    t = 0; tl = 0; tch = 0; drop = 0;
    if (!e_scan) begin
      if (run && ch_mask != 8'h00) begin
        e_scan = 1; e_have = 0;
        e_mask = ch_mask; e_sleep = sleep_req; e_cur = low_of(ch_mask);
      end
    end else if (!run) begin
      e_scan = 0; e_have = 0;
    end else if (adc_ready) begin
      if (e_have) begin
        t = 1; tch = e_pend; tl = (e_pend == high_of(e_mask));
      end
      e_pend = e_cur; e_have = 1;
      n = above(e_mask, e_cur);
      if (n >= 0) begin
        e_cur = n;
      end else begin
        e_mask = ch_mask; e_sleep = sleep_req;
        if (ch_mask == 8'h00) begin
          e_scan = 0; e_have = 0;
        end else begin
          e_cur = low_of(ch_mask);
        end
      end
    end
    if (t && (!e_valid || m_ready)) begin
      e_valid = 1; e_data = adc_data; e_ch = tch; e_last = tl;
    end else if (t) begin
      drop = 1;
    end else if (m_ready) begin
      e_valid = 0;
    end
    if (drop) e_ovr = 1;
    else if (overrun_clr) e_ovr = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n) begin
        chk("start",   32'(adc_start),   32'(e_scan));
        chk("busy",    32'(busy),        32'(e_scan));
        chk("channel", 32'(adc_channel), 32'({1'b0, e_cur[2:0]}));
        chk("sleep",   32'(adc_sleep),   32'(e_sleep));
        chk("valid",   32'(m_valid),     32'(e_valid));
        chk("overrun", 32'(overrun),     32'(e_ovr));
        if (e_valid) begin
          chk("data", 32'(m_data), 32'(e_data));
          chk("ch",   32'(m_ch),   32'(e_ch));
          chk("last", 32'(m_last), 32'(e_last));
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_sample(output logic [11:0] d, output logic [2:0] c,
                             output logic l, output int waited);
    bit ok;
    ok = 0; d = '0; c = '0; l = 1'b0; waited = 0;
    for (int n = 0; n < 3 * FRAME; n++) begin
      @(negedge clock);
      waited++;
      if (m_valid) begin
        d = m_data; c = m_ch; l = m_last; ok = 1;
        break;
      end
    end
    if (!ok) chk("sample_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [11:0] d;
    logic [2:0]  c;
    logic        l;
    int          w, cnt;
    int          seq [6];
    seq = '{1, 0, 1, 4, 5, 4};

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_start",   32'(adc_start),   32'd0);
    chk("rst_busy",    32'(busy),        32'd0);
    chk("rst_valid",   32'(m_valid),     32'd0);
    chk("rst_overrun", 32'(overrun),     32'd0);
    chk("rst_channel", 32'(adc_channel), 32'd0);
    chk("rst_data",    32'(m_data),      32'd0);
    reset_n = 1'b1;
    m_ready = 1'b1;
    @(negedge clock);

    // 1: mask 0b101, first frame discarded, then 0,2,0
    ch_mask = 8'h05; run = 1'b1;
    wait_sample(d, c, l, w);
    chk("t1_ch0", 32'(c), 32'd0); chk("t1_d0", 32'(d), 32'h0A5); chk("t1_l0", 32'(l), 32'd0);
    wait_sample(d, c, l, w);
    chk("t1_ch1", 32'(c), 32'd2); chk("t1_d1", 32'(d), 32'h4A5); chk("t1_l1", 32'(l), 32'd1);
    wait_sample(d, c, l, w);
    chk("t1_ch2", 32'(c), 32'd0); chk("t1_d2", 32'(d), 32'h0A5);

    // 2: single channel 7, sleep latched at start and at each wrap
    run = 1'b0;
    repeat (3) @(negedge clock);
    chk("t2_idle", 32'(busy), 32'd0);
    ch_mask = 8'h80; sleep_req = 1'b1; run = 1'b1;
    @(negedge clock);
    chk("t2_chan", 32'(adc_channel), 32'h7);
    chk("t2_sleep", 32'(adc_sleep), 32'd1);
    wait_sample(d, c, l, w);
    chk("t2_ch", 32'(c), 32'd7); chk("t2_d", 32'(d), 32'hEA5); chk("t2_l", 32'(l), 32'd1);
    sleep_req = 1'b0;
    wait_sample(d, c, l, w);
    chk("t2_ch_b", 32'(c), 32'd7); chk("t2_sleep_off", 32'(adc_sleep), 32'd0);

    // 3: stall downstream across a frame -> held sample, drop, overrun
    m_ready = 1'b0;
    repeat (FRAME + 5) @(negedge clock);
    chk("t3_held", 32'(m_valid), 32'd1);
    chk("t3_held_d", 32'(m_data), 32'hEA5);
    chk("t3_ovr", 32'(overrun), 32'd1);
    m_ready = 1'b1; overrun_clr = 1'b1;
    @(negedge clock);
    overrun_clr = 1'b0;
    chk("t3_clr", 32'(overrun), 32'd0);
    chk("t3_drain", 32'(m_valid), 32'd0);

    // 4: drop run mid-frame, then restart with a fresh discard
    wait_sample(d, c, l, w);
    repeat (40) @(negedge clock);
    run = 1'b0;
    @(negedge clock);
    chk("t4_start_off", 32'(adc_start), 32'd0);
    cnt = 0;
    repeat (2 * FRAME) begin
      @(negedge clock);
      if (m_valid) cnt++;
    end
    chk("t4_quiet", 32'(cnt), 32'd0);
    ch_mask = 8'h05; run = 1'b1;
    wait_sample(d, c, l, w);
    chk("t4_latency", 32'(w), 32'd161);
    chk("t4_ch", 32'(c), 32'd0); chk("t4_d", 32'(d), 32'h0A5);

    // 5: mask change mid-scan takes effect only after wrap
    run = 1'b0;
    repeat (3) @(negedge clock);
    ch_mask = 8'h03; run = 1'b1;
    wait_sample(d, c, l, w);
    chk("t5_first", 32'(c), 32'd0);
    ch_mask = 8'h30;
    for (int k = 0; k < 6; k++) begin
      wait_sample(d, c, l, w);
      chk("t5_seq_ch", 32'(c), 32'(seq[k]));
      chk("t5_seq_d", 32'(d), 32'({3'(seq[k]), 9'h0A5}));
      if (k == 0 || k == 4) chk("t5_last", 32'(l), 32'd1);
    end
`ifdef ADC_SEQ_HOLD_EN
    rd_ch = 3'd5;
    #1 chk("t5_bank", 32'(rd_data), 32'hAA5);
`endif

    // 6: async reset while a sample is held
    m_ready = 1'b0;
    wait_sample(d, c, l, w);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_valid", 32'(m_valid), 32'd0);
    chk("t6_start", 32'(adc_start), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_data", 32'(m_data), 32'd0);
    chk("t6_ch", 32'(m_ch), 32'd0);
    chk("t6_last", 32'(m_last), 32'd0);
    chk("t6_chan", 32'(adc_channel), 32'd0);
    chk("t6_ovr", 32'(overrun), 32'd0);
`ifdef ADC_SEQ_HOLD_EN
    for (int k = 0; k < 8; k++) begin
      rd_ch = 3'(k);
      #1 chk("t6_bank", 32'(rd_data), 32'd0);
    end
`endif
    run = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
